usart_rx_fifo: RTL and testbench

USART_RX_FIFO -- requirements
Module: usart_rx_fifo

---
 rtl/usart_pkg.sv | 11 +
 rtl/usart_rx_fifo_if.sv | 40 ++++
 rtl/usart_fifo_mem.sv | 29 ++
 rtl/usart_rx_fifo.sv | 107 ++++++++++
 tb/tb_usart_rx_fifo.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/usart_pkg.sv
// Shared constants and types for the USART receive path.
package usart_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t LF = 8'h0A;

endpackage

// File: rtl/usart_rx_fifo_if.sv
// Bundle of receiver-side and consumer-side signals of the RX FIFO.
// Optional line_avail signal exists only when USART_RX_FIFO_LINE_EN is defined.
interface usart_rx_fifo_if
  import usart_pkg::*;
#(
  parameter int ADDR_W = 4
) ();

  byte_t             rx_data;
  logic              rx_done;
  byte_t             rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overrun;
  logic              overrun_clr;
`ifdef USART_RX_FIFO_LINE_EN
  logic              line_avail;
`endif

  // The FIFO itself.
  modport slave (
    input  rx_data, rx_done, rd_ready, overrun_clr,
    output rd_data, rd_valid, count, full, overrun
`ifdef USART_RX_FIFO_LINE_EN
    , output line_avail
`endif
  );

  // The UART receiver plus the consumer that surround the FIFO.
  modport master (
    output rx_data, rx_done, rd_ready, overrun_clr,
    input  rd_data, rd_valid, count, full, overrun
`ifdef USART_RX_FIFO_LINE_EN
    , input line_avail
`endif
  );

endinterface

// File: rtl/usart_fifo_mem.sv
// Byte storage for the RX FIFO: one synchronous write port, one asynchronous
// read port, no reset.
module usart_fifo_mem
  import usart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  byte_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output byte_t             rdata
);

  byte_t mem [DEPTH];

  // Store the incoming byte at the write address.
  // NOTE: storage has no reset; validity is tracked by the pointers, and a
  // reset-free array maps onto distributed RAM. Sequential state uses <= so
  // every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usart_rx_fifo.sv
// First-word-fall-through byte FIFO behind a UART receiver. rx_done is
// edge-detected so a held strobe pushes once; bytes arriving while full are
// dropped and flagged in the sticky overrun bit.
// Optional feature: define USART_RX_FIFO_LINE_EN to add line_avail, which is
// high while at least one stored byte is a line feed.
module usart_rx_fifo
  import usart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  usart_rx_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic            rx_done_q;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count_w;
  logic            full_w;
  logic            rd_valid_w;
  logic            push;
  logic            pop;
  logic            accept;
  logic            overflow;
  logic            overrun_q;

  // Extra pointer bit distinguishes full from empty; difference wraps naturally.
  assign count_w    = wr_ptr - rd_ptr;
  assign full_w     = (count_w == DEPTH_C);
  assign rd_valid_w = (count_w != '0);

  // Decide whether this edge stores the byte, drops it, and/or pops the head.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    accept   = 1'b0;
    overflow = 1'b0;
    push     = bus.rx_done & ~rx_done_q;
    pop      = rd_valid_w & bus.rd_ready;
    if (push) begin
      if (!full_w || pop) accept   = 1'b1;
      else                overflow = 1'b1;
    end
  end

  // Strobe edge detector, pointers and sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_q <= 1'b0;
    end else begin
      rx_done_q <= bus.rx_done;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      // A fresh drop takes priority over a clear in the same cycle.
      if (overflow)             overrun_q <= 1'b1;
      else if (bus.overrun_clr) overrun_q <= 1'b0;
    end
  end

  usart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.rx_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid = rd_valid_w;
  assign bus.count    = count_w;
  assign bus.full     = full_w;
  assign bus.overrun  = overrun_q;

`ifdef USART_RX_FIFO_LINE_EN
  logic [ADDR_W:0] line_cnt;
  logic            lf_in;
  logic            lf_out;

  assign lf_in  = accept & (bus.rx_data == LF);
  assign lf_out = pop & (bus.rd_data == LF);

  // Count line feeds currently held; simultaneous in and out cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_cnt <= '0;
    end else if (lf_in && !lf_out) begin
      line_cnt <= line_cnt + 1'b1;
    end else if (lf_out && !lf_in) begin
      line_cnt <= line_cnt - 1'b1;
    end
  end

  assign bus.line_avail = (line_cnt != '0);
`endif

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Self-checking bench for usart_rx_fifo: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_usart_rx_fifo;
  import usart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  usart_rx_fifo_if #(.ADDR_W(AW)) bus_if ();

  usart_rx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: stored bytes in arrival order, last rx_done level, flag.
  byte_t model_q[$];
  logic  model_prev;
  logic  model_ovr;

  typedef struct {
    logic  rxd;
    byte_t d;
    logic  rdy;
    logic  clr;
    logic  e_valid;
    byte_t e_data;
    int    e_count;
    logic  e_ovr;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_lines();
    int n = 0;
    foreach (model_q[i]) if (model_q[i] == LF) n++;
    return n;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".valid"},   32'(bus_if.rd_valid), 32'(model_q.size() != 0));
    check({tag, ".count"},   32'(bus_if.count),    32'(model_q.size()));
    check({tag, ".full"},    32'(bus_if.full),     32'(model_q.size() == DEPTH));
    check({tag, ".overrun"}, 32'(bus_if.overrun),  32'(model_ovr));
    if (model_q.size() != 0)
      check({tag, ".data"}, 32'(bus_if.rd_data), 32'(model_q[0]));
`ifdef USART_RX_FIFO_LINE_EN
    check({tag, ".line"}, 32'(bus_if.line_avail), 32'(model_lines() != 0));
`endif
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare.
  task automatic cycle(input logic rxd, input byte_t d, input logic rdy, input logic clr);
    bit pop_m, push_m, keep;
    bus_if.rx_done     = rxd;
    bus_if.rx_data     = d;
    bus_if.rd_ready    = rdy;
    bus_if.overrun_clr = clr;
    pop_m  = (model_q.size() != 0) && rdy;
    push_m = rxd && !model_prev;
    keep   = push_m && ((model_q.size() < DEPTH) || pop_m);
    if (push_m && !keep) model_ovr = 1'b1;
    else if (clr)        model_ovr = 1'b0;
    if (pop_m) void'(model_q.pop_front());
    if (keep)  model_q.push_back(d);
    model_prev = rxd;
    @(posedge clk);
    #1;
    check_model("model");
  endtask

  task automatic model_clear();
    model_q.delete();
    model_prev = 1'b0;
    model_ovr  = 1'b0;
  endtask

  // Hold reset over two edges with rx_done at the given level, release off-edge.
  task automatic do_reset(input logic rxd);
    bus_if.rx_done     = rxd;
    bus_if.rx_data     = 8'h00;
    bus_if.rd_ready    = 1'b0;
    bus_if.overrun_clr = 1'b0;
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    do_reset(1'b0);

    // Reset state.
    check("rst.valid",   32'(bus_if.rd_valid), 0);
    check("rst.count",   32'(bus_if.count),    0);
    check("rst.full",    32'(bus_if.full),     0);
    check("rst.overrun", 32'(bus_if.overrun),  0);

    // Directed table: single pulse, held strobe, push while empty with ready.
    tbl[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    for (int i = 2; i <= 6; i++)
      tbl[i] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA3, 1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA3, 1, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[9]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].rxd, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      check($sformatf("tbl%0d.valid", i), 32'(bus_if.rd_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d.count", i), 32'(bus_if.count),    32'(tbl[i].e_count));
      check($sformatf("tbl%0d.ovr", i),   32'(bus_if.overrun),  32'(tbl[i].e_ovr));
      if (tbl[i].e_valid)
        check($sformatf("tbl%0d.data", i), 32'(bus_if.rd_data), 32'(tbl[i].e_data));
    end

    // Seventeen pushes into a 16-deep FIFO: last one dropped, overrun set.
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, byte_t'(i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("ovf.full",    32'(bus_if.full),    1);
    check("ovf.count",   32'(bus_if.count),   16);
    check("ovf.overrun", 32'(bus_if.overrun), 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf.rd%0d", i), 32'(bus_if.rd_data), 32'(i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("ovf.empty", 32'(bus_if.count), 0);
    check("ovf.sticky", 32'(bus_if.overrun), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf.clr", 32'(bus_if.overrun), 0);

    // Full FIFO, push and pop together: both accepted, no overrun.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, byte_t'(8'h20 + i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("fpp.full", 32'(bus_if.full), 1);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    check("fpp.count",   32'(bus_if.count),   16);
    check("fpp.overrun", 32'(bus_if.overrun), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("fpp.last", 32'(bus_if.rd_data), 32'h77);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Overflow and clear in the same cycle: set wins.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, byte_t'(i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    check("setwin.overrun", 32'(bus_if.overrun), 1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);

    // Randomized interleaved traffic across many pointer wraps.
    for (int seg = 0; seg < 8; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 2 == 0) ? 20 : 80;
      for (int n = 0; n < 80; n++) begin
        cycle(1'($urandom_range(0, 1)), byte_t'($urandom),
              1'($urandom_range(0, 99) < rdy_pct), 1'($urandom_range(0, 15) == 0));
        check("rand.count_max", 32'(bus_if.count <= 5'(DEPTH)), 1);
      end
    end

    // Line feed tracking and mid-stream reset.
    do_reset(1'b0);
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, LF,    1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h42, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef USART_RX_FIFO_LINE_EN
    check("line.avail", 32'(bus_if.line_avail), 1);
`endif
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef USART_RX_FIFO_LINE_EN
    check("line.gone", 32'(bus_if.line_avail), 0);
`endif
    cycle(1'b1, 8'h43, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, LF,    1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("mid.count3", 32'(bus_if.count), 3);
    reset = 1'b1;
    #1;
    check("mid.count", 32'(bus_if.count),    0);
    check("mid.valid", 32'(bus_if.rd_valid), 0);
`ifdef USART_RX_FIFO_LINE_EN
    check("mid.line", 32'(bus_if.line_avail), 0);
`endif

    // rx_done high across reset release pushes exactly once afterwards.
    do_reset(1'b1);
    check("rstedge.count0", 32'(bus_if.count), 0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    check("rstedge.count1", 32'(bus_if.count), 1);
    check("rstedge.data",   32'(bus_if.rd_data), 32'h3C);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    check("rstedge.once", 32'(bus_if.count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
